sync_filter_bank: RTL and testbench
===================================

Name: sync_filter_bank

Overview:
- Parametrised, multi-channel successor to the single-bit input synchroniser.
- Each of WIDTH asynchronous inputs passes through an N-stage metastability chain, then a per-channel glitch filter (debounce counter) with optional sample-enable prescaling.
- Per-channel registered rise/fall strobes are produced.
- Sits between pads (UART rx, buttons, external handshake lines) and core logic.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchroniser flops per channel; legal range 2..4.
- FILTER_LEN, 4, consecutive qualifying samples required before the output changes; legal range 1..255.
- RESET_VAL, {WIDTH{1'b1}}, per-channel reset level (idle-high, suits UART rx).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- async_in  input  WIDTH  asynchronous inputs.
- sample_en  input  1  filter sample strobe; tie 1 for per-clock filtering.
- sync_out  output  WIDTH  synchronised, filtered level.
- rise  output  WIDTH  one-cycle pulse when sync_out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when sync_out[i] goes 1->0.
- any_edge  output  1  registered OR of rise|fall across all channels.

Behaviour:
- Reset:
  - One clock, synchronous, active-low; rst_n sampled on posedge clk.
  - During reset, all chain flops and sync_out[i] take RESET_VAL[i].
  - Counters, rise, fall and any_edge are cleared to 0.
  - The reset value wins over every other event in the same cycle.
- Sync chain:
  - meta[0] <= async_in[i] and meta[k] <= meta[k-1] every clock, independent of sample_en.
  - s = meta[STAGES-1].
- Filter (per channel, counter width clog2(FILTER_LEN+1)):
  - It acts only on cycles with sample_en=1.
  - If s == sync_out[i], cnt <= 0.
  - Else if cnt == FILTER_LEN-1: sync_out[i] <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - With sample_en=0, cnt and sync_out hold.
- Latency:
  - Conditions: sample_en=1 throughout, and a clean step sampled first at edge E1.
  - sync_out changes after edge E(STAGES+FILTER_LEN).
  - Defaults: visible after the 6th edge.
  - FILTER_LEN=1: latency STAGES+1, matching the previous synchroniser.
- Glitch rejection:
  - A mismatch lasting fewer than FILTER_LEN sampled cycles resets cnt once s returns to sync_out.
  - In that case sync_out does not toggle.
- Edge strobes:
  - rise[i] / fall[i] are registered.
  - They are high exactly in the cycle sync_out[i] shows its new value, and for one cycle only.
  - any_edge asserts in that same cycle.
  - Several channels may pulse in one cycle, with no arbitration.
- Channels are fully independent; no cross-channel coherence is guaranteed. Multi-bit buses must not be passed through this block.
- Reset mid-operation:
  - Pending counts are discarded.
  - No rise/fall is generated by reset itself or on the first cycle after release.
- Reset release while async_in differs from RESET_VAL:
  - The mismatch is filtered normally.
  - The first change produces a strobe after STAGES+FILTER_LEN edges.

Decomposition:
- Shared package holds:
  - the clog2 function for the counter width;
  - SYNC_STAGES_MIN = 2;
  - FILTER_LEN_MAX = 255.
- Parameters are checked at elaboration; violations are a fatal error.
- One sub-module, sync_filter_chan: chain, counter, level register and rise/fall for one bit.
- The top instantiates it WIDTH times via generate and ORs the strobes into any_edge.

Test Plan:
- Reset value: WIDTH=2, RESET_VAL=2'b10, async_in=2'b01 during reset.
  - After release: sync_out=2'b10 and no strobes in the first cycle.
  - sync_out=2'b01 after 6 edges.
  - fall[1] and rise[0] pulse in the same cycle, with any_edge=1.
- Step latency: defaults, async_in[0] 1->0 held.
  - sync_out[0] falls after exactly edge 6.
  - fall[0] is high for exactly 1 cycle.
- Glitch rejection: async_in[0] low for 3 clocks, then high.
  - sync_out[0] stays 1; no strobes.
  - Repeat with a 4-clock low: sync_out[0] goes low.
- Prescaled sampling: sample_en pulsed every 4th cycle, FILTER_LEN=4, step held for 20 clocks.
  - The change occurs only after the 4th qualifying strobe.
  - Output holds between strobes.
- Reset mid-count: step applied, rst_n asserted 1 cycle at cnt=2.
  - After release, sync_out=RESET_VAL and no spurious strobe.
  - The change then takes the full STAGES+FILTER_LEN.
- FILTER_LEN=1, STAGES=3: random async_in.
  - sync_out equals async_in delayed by exactly 4 edges.
  - rise/fall match a scoreboard edge detector.

Source files
------------

// File: rtl/sync_filter_bank_pkg.sv
// Shared definitions for the synchroniser / glitch-filter bank.
//   SYNC_STAGES_MIN/MAX : legal range of metastability chain length
//   FILTER_LEN_MAX      : largest supported debounce length
//   cnt_clog2()         : ceiling log2, sizes the per-channel debounce counter
package sync_filter_bank_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILTER_LEN_MAX  = 255;

  // Ceiling log2 of value (value >= 2 gives a result >= 1).
  function automatic int cnt_clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of the filter bank: metastability chain, debounce counter,
// filtered level register and registered rise/fall strobes.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   async_in    : raw asynchronous input bit
//   sample_en   : filter sample strobe (chain runs every clock regardless)
//   sync_out    : synchronised, filtered level
//   rise, fall  : one-cycle strobes, high in the cycle sync_out shows its new value
//   edge_next   : combinational rise|fall for the coming edge, lets the top
//                 register any_edge so it lines up with rise/fall
module sync_filter_chan
  import sync_filter_bank_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_BIT  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic sample_en,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic edge_next
);

  localparam int              CNT_W    = cnt_clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // meta[0] is the first flop after the pad, meta[STAGES-1] the safe sample.
  logic [STAGES-1:0] meta;
  logic              s;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              sync_next;
  logic              rise_next;
  logic              fall_next;

  assign s         = meta[STAGES-1];
  assign edge_next = rise_next | fall_next;

  // The counter tracks consecutive sampled cycles in which s disagrees with
  // the filtered level; any agreeing sample throws the partial count away.
  always_comb begin
    cnt_next  = cnt;
    sync_next = sync_out;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (sample_en) begin
      if (s == sync_out) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_next  = '0;
        sync_next = s;
        rise_next = s;
        fall_next = ~s;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= {STAGES{RESET_BIT}};
      sync_out <= RESET_BIT;
      cnt      <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      meta     <= {meta[STAGES-2:0], async_in};
      sync_out <= sync_next;
      cnt      <= cnt_next;
      rise     <= rise_next;
      fall     <= fall_next;
    end
  end

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel input synchroniser with per-channel glitch filtering and
// edge strobes. Channels are independent; never pass a multi-bit bus through.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   async_in   : WIDTH asynchronous pad inputs
//   sample_en  : filter sample strobe (tie 1 for per-clock filtering)
//   sync_out   : WIDTH filtered levels, reset to RESET_VAL
//   rise, fall : WIDTH one-cycle edge strobes
//   any_edge   : registered OR of all rise/fall, aligned with the strobes
module sync_filter_bank
  import sync_filter_bank_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  if (WIDTH < 1 || STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX ||
      FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_param_err
    $fatal(1, "sync_filter_bank: illegal parameters WIDTH=%0d STAGES=%0d FILTER_LEN=%0d",
           WIDTH, STAGES, FILTER_LEN);
  end

  logic [WIDTH-1:0] edge_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_BIT  (RESET_VAL[i])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (async_in[i]),
      .sample_en (sample_en),
      .sync_out  (sync_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .edge_next (edge_next[i])
    );
  end

  // Registered from the channels' next-cycle strobes so it asserts in the
  // same cycle as the rise/fall it summarises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_edge <= 1'b0;
    end else begin
      any_edge <= |edge_next;
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
module tb_sync_filter_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=2, defaults otherwise, RESET_VAL=2'b10
  logic       rst_n_a = 1'b0;
  logic [1:0] in_a    = 2'b01;
  logic       en_a    = 1'b1;
  logic [1:0] sync_a, rise_a, fall_a;
  logic       any_a;

  // Instance B: WIDTH=1, STAGES=3, FILTER_LEN=1
  logic       rst_n_b = 1'b0;
  logic [0:0] in_b    = 1'b1;
  logic       en_b    = 1'b1;
  logic [0:0] sync_b, rise_b, fall_b;
  logic       any_b;

  sync_filter_bank #(
    .WIDTH(2), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(2'b10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .async_in(in_a), .sample_en(en_a),
    .sync_out(sync_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a)
  );

  sync_filter_bank #(
    .WIDTH(1), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .async_in(in_b), .sample_en(en_b),
    .sync_out(sync_b), .rise(rise_b), .fall(fall_b), .any_edge(any_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [1:0] in;
    logic       en;
    logic [1:0] exp_sync;
    logic [1:0] exp_rise;
    logic [1:0] exp_fall;
    logic       exp_any;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic r, input logic [1:0] i, input logic e,
                       input logic [1:0] so, input logic [1:0] ri, input logic [1:0] fa,
                       input logic an);
    vec_t v;
    v.rst_n = r; v.in = i; v.en = e;
    v.exp_sync = so; v.exp_rise = ri; v.exp_fall = fa; v.exp_any = an;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_vec_a(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    rst_n_a = v.rst_n;
    in_a    = v.in;
    en_a    = v.en;
    @(posedge clk);
    #1;
    check($sformatf("a v%0d sync_out", idx), int'(sync_a), int'(v.exp_sync));
    check($sformatf("a v%0d rise", idx),     int'(rise_a), int'(v.exp_rise));
    check($sformatf("a v%0d fall", idx),     int'(fall_a), int'(v.exp_fall));
    check($sformatf("a v%0d any_edge", idx), int'(any_a),  int'(v.exp_any));
  endtask

  logic [0:0] exp_q[$];

  task automatic run_b_random(input int cycles);
    logic [0:0] exp_v;
    logic [0:0] prev;
    // chain and level all reset to 1, so the first three results are 1
    exp_q = '{1'b1, 1'b1, 1'b1};
    prev  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst_n_b = 1'b1;
      in_b    = 1'($urandom_range(0, 1));
      exp_q.push_back(in_b);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check($sformatf("b c%0d sync_out", c), int'(sync_b), int'(exp_v));
      check($sformatf("b c%0d rise", c), int'(rise_b), int'(~prev & exp_v));
      check($sformatf("b c%0d fall", c), int'(fall_b), int'(prev & ~exp_v));
      check($sformatf("b c%0d any_edge", c), int'(any_b), int'(prev ^ exp_v));
      prev = exp_v;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // Reset value: async_in=01 during reset, RESET_VAL=10
    add_n(1, 1'b0, 2'b01, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    add_n(5, 1'b1, 2'b01, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 2'b10, 1'b1);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    // Step latency: ch0 1->0, change after edge 6, fall one cycle
    add_n(5, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1);
    add_n(1, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    // Back high
    add_n(5, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1);
    add_n(2, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    // 3-clock glitch: rejected
    add_n(3, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    add_n(7, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    // 4-clock low: accepted, then returns high after another 4 samples
    add_n(4, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1);
    add_n(3, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1);
    add_n(1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    // Prescaled: sample_en every 4th cycle, step held 20 clocks;
    // 4th qualifying strobe at cycle 15
    for (int c = 0; c < 20; c++) begin
      add_n(1, 1'b1, 2'b00, (c % 4) == 3,
            (c >= 15) ? 2'b00 : 2'b01, 2'b00,
            (c == 15) ? 2'b01 : 2'b00, c == 15);
    end
    // Reset mid-count: step to 11, reset at cnt=2, then full latency again
    add_n(4, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    add_n(5, 1'b1, 2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    add_n(1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b01, 2'b00, 1'b1);
    add_n(1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply_vec_a(i);

    // Instance B reset state (held in reset with async_in=0 to show reset wins)
    @(negedge clk);
    in_b = 1'b0;
    @(posedge clk);
    #1;
    check("b reset sync_out", int'(sync_b), 1);
    check("b reset rise", int'(rise_b), 0);
    check("b reset fall", int'(fall_b), 0);
    check("b reset any_edge", int'(any_b), 0);

    // FILTER_LEN=1, STAGES=3: plain 4-edge delay with edge detection
    run_b_random(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
